// File: rtl/write_back.sv
// Write-back stage: load lane extraction, register-file write port,
// halt-drain sequencing and retired-instruction counting.
module write_back #(
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int NB_CNT       = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_valid,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_reg_read,
    input  logic [NB_DATA-1:0] i_ALUresult,
    input  logic [NB_REG-1:0]  i_reg2write,
    input  logic               i_mem2reg,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    output logic               o_wb_en,
    output logic [NB_REG-1:0]  o_wb_addr,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic               o_halted,
    output logic               o_align_err,
    output logic [NB_CNT-1:0]  o_retired_cnt
);

    localparam int NB_DRN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRN-1:0] DRAIN_INIT = NB_DRN'(DRAIN_CYCLES - 1);

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [NB_DRN-1:0]   drain_q, drain_d;

    logic                wb_en_q;
    logic [NB_REG-1:0]   wb_addr_q;
    logic [NB_DATA-1:0]  wb_data_q;
    logic                halted_q;
    logic                align_q;
    logic [NB_CNT-1:0]   cnt_q;

    logic                run;
    logic                fire;
    logic                commit;
    logic                misalign;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [NB_DATA-1:0]  load_ext;
    logic [NB_DATA-1:0]  wdata;

    // Little-endian lane pick from the raw memory word
    always_comb begin
        byte_lane = 8'h00;
        unique case (i_ALUresult[1:0])
            2'd0: byte_lane = i_reg_read[7:0];
            2'd1: byte_lane = i_reg_read[15:8];
            2'd2: byte_lane = i_reg_read[23:16];
            2'd3: byte_lane = i_reg_read[31:24];
        endcase
        half_lane = i_ALUresult[1] ? i_reg_read[31:16] : i_reg_read[15:0];
    end

    always_comb begin
        load_ext = '0;
        unique case (i_width)
            W_BYTE:
                load_ext = {{(NB_DATA-8){i_sign_flag & byte_lane[7]}},
                            byte_lane};
            W_HALF:
                load_ext = {{(NB_DATA-16){i_sign_flag & half_lane[15]}},
                            half_lane};
            W_WORD:
                load_ext = i_reg_read;
            default:
                load_ext = '0;
        endcase
    end

    assign wdata = i_mem2reg ? i_ALUresult : load_ext;

    assign run    = (state_q == ST_RUN);
    assign fire   = run & i_valid & ~i_stall;
    assign commit = fire & i_regWrite & ~i_halt & (i_reg2write != '0);

    always_comb begin
        misalign = 1'b0;
        if (fire && !i_mem2reg) begin
            unique case (i_width)
                W_HALF:  misalign = i_ALUresult[0];
                W_WORD:  misalign = (i_ALUresult[1:0] != 2'b00);
                default: misalign = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_RUN: begin
                if (fire && i_halt) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Address/data hold between commits so a stall cannot re-write
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q <= commit;
            if (commit) begin
                wb_addr_q <= i_reg2write;
                wb_data_q <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            halted_q <= 1'b0;
            align_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            halted_q <= (state_d == ST_HALTED);
            align_q  <= align_q | misalign;
            cnt_q    <= cnt_q + NB_CNT'(fire);
        end
    end

    assign o_wb_en       = wb_en_q;
    assign o_wb_addr     = wb_addr_q;
    assign o_wb_data     = wb_data_q;
    assign o_halted      = halted_q;
    assign o_align_err   = align_q;
    assign o_retired_cnt = cnt_q;

endmodule

// File: tb/tb_write_back.sv
// Bench for write_back: directed cases plus random traffic checked
// against a per-instruction reference model.
module tb_write_back;

    localparam int DRAIN = 2;

    logic        clk;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_valid;
    logic        i_halt;
    logic [31:0] i_reg_read;
    logic [31:0] i_ALUresult;
    logic [4:0]  i_reg2write;
    logic        i_mem2reg;
    logic        i_regWrite;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic        o_wb_en;
    logic [4:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        o_halted;
    logic        o_align_err;
    logic [31:0] o_retired_cnt;

    write_back #(
        .NB_DATA(32), .NB_REG(5), .NB_CNT(32), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
        .i_valid(i_valid), .i_halt(i_halt), .i_reg_read(i_reg_read),
        .i_ALUresult(i_ALUresult), .i_reg2write(i_reg2write),
        .i_mem2reg(i_mem2reg), .i_regWrite(i_regWrite),
        .i_width(i_width), .i_sign_flag(i_sign_flag),
        .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .o_halted(o_halted), .o_align_err(o_align_err),
        .o_retired_cnt(o_retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_align;
    logic [31:0] m_cnt;
    logic        m_halted;
    bit          m_halt_seen;
    int          m_halt_at;
    int          m_cyc;
    logic [31:0] cnt_snap;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word,
        input logic [31:0] addr, input logic [1:0] w, input bit sg);
        logic [31:0] v;
        int bits;
        case (w)
            2'd0: begin v = (word >> (8 * addr[1:0])) & 32'hFF; bits = 8; end
            2'd1: begin v = (word >> (16 * addr[1])) & 32'hFFFF; bits = 16; end
            2'd2: return word;
            default: return 32'h0;
        endcase
        if (sg && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
        return v;
    endfunction

    task automatic model_reset();
        m_en = 0; m_addr = 0; m_data = 0; m_align = 0; m_cnt = 0;
        m_halted = 0; m_halt_seen = 0; m_halt_at = 0; m_cyc = 0;
    endtask

    // Effect of one clock edge given the instruction presented to it
    task automatic model_step();
        int p;
        p = m_cyc;
        m_cyc++;
        m_en = 0;
        if (!m_halt_seen && i_valid && !i_stall) begin
            m_cnt = m_cnt + 1;
            if (!i_mem2reg &&
                ((i_width == 2'd1 && i_ALUresult[0]) ||
                 (i_width == 2'd2 && i_ALUresult[1:0] != 0)))
                m_align = 1;
            if (i_halt) begin
                m_halt_seen = 1;
                m_halt_at = p;
            end else if (i_regWrite && i_reg2write != 0) begin
                m_en = 1;
                m_addr = i_reg2write;
                m_data = i_mem2reg ? i_ALUresult
                       : ref_load(i_reg_read, i_ALUresult, i_width, i_sign_flag);
            end
        end
        m_halted = m_halt_seen && (p - m_halt_at >= DRAIN);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".en"}, 64'(o_wb_en), 64'(m_en));
        chk({tag, ".addr"}, 64'(o_wb_addr), 64'(m_addr));
        chk({tag, ".data"}, 64'(o_wb_data), 64'(m_data));
        chk({tag, ".align"}, 64'(o_align_err), 64'(m_align));
        chk({tag, ".cnt"}, 64'(o_retired_cnt), 64'(m_cnt));
        chk({tag, ".halted"}, 64'(o_halted), 64'(m_halted));
    endtask

    task automatic cycle(input bit v, input bit h, input logic [31:0] word,
        input logic [31:0] alu, input logic [4:0] rd, input bit m2r,
        input bit rw, input logic [1:0] w, input bit sg, input bit st,
        input string tag);
        i_valid = v; i_halt = h; i_reg_read = word; i_ALUresult = alu;
        i_reg2write = rd; i_mem2reg = m2r; i_regWrite = rw;
        i_width = w; i_sign_flag = sg; i_stall = st;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic bubble(input string tag);
        cycle(0, 0, 32'h0, 32'h0, 5'd0, 1, 0, 2'd2, 0, 0, tag);
    endtask

    task automatic do_reset(input string tag);
        i_rst_n = 1'b0;
        #1;
        chk({tag, ".rst_en"}, 64'(o_wb_en), 64'd0);
        chk({tag, ".rst_addr"}, 64'(o_wb_addr), 64'd0);
        chk({tag, ".rst_data"}, 64'(o_wb_data), 64'd0);
        chk({tag, ".rst_halted"}, 64'(o_halted), 64'd0);
        chk({tag, ".rst_align"}, 64'(o_align_err), 64'd0);
        chk({tag, ".rst_cnt"}, 64'(o_retired_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n = 0; i_stall = 0; i_valid = 0; i_halt = 0;
        i_reg_read = 0; i_ALUresult = 0; i_reg2write = 0;
        i_mem2reg = 0; i_regWrite = 0; i_width = 0; i_sign_flag = 0;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // Byte loads, signed then unsigned
        cycle(1, 0, 32'h8081_82F3, 32'h0000_1001, 5'd4, 0, 1, 2'd0, 1, 0, "lb_s");
        chk("lb_s.fixed", 64'(o_wb_data), 64'hFFFF_FF82);
        chk("lb_s.fixaddr", 64'(o_wb_addr), 64'd4);
        cycle(1, 0, 32'h8081_82F3, 32'h0000_1001, 5'd4, 0, 1, 2'd0, 0, 0, "lb_u");
        chk("lb_u.fixed", 64'(o_wb_data), 64'h0000_0082);

        // Half loads: aligned, then misaligned (sticky flag)
        cycle(1, 0, 32'h8081_82F3, 32'h0000_1002, 5'd5, 0, 1, 2'd1, 1, 0, "lh2");
        chk("lh2.fixed", 64'(o_wb_data), 64'hFFFF_8081);
        chk("lh2.noalign", 64'(o_align_err), 64'd0);
        cycle(1, 0, 32'h8081_82F3, 32'h0000_1003, 5'd6, 0, 1, 2'd1, 1, 0, "lh3");
        chk("lh3.fixed", 64'(o_wb_data), 64'hFFFF_8081);
        chk("lh3.align", 64'(o_align_err), 64'd1);
        bubble("sticky");
        chk("sticky.align", 64'(o_align_err), 64'd1);

        // ALU op to x0 retires without writing, then to x7
        cnt_snap = o_retired_cnt;
        cycle(1, 0, 32'h0, 32'h1234_5678, 5'd0, 1, 1, 2'd2, 0, 0, "alu_x0");
        chk("alu_x0.en", 64'(o_wb_en), 64'd0);
        chk("alu_x0.cnt", 64'(o_retired_cnt), 64'(cnt_snap + 1));
        cycle(1, 0, 32'h0, 32'h1234_5678, 5'd7, 1, 1, 2'd2, 0, 0, "alu_x7");
        chk("alu_x7.data", 64'(o_wb_data), 64'h1234_5678);

        // Stalled write: one pulse after release
        cnt_snap = o_retired_cnt;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 32'h0, 32'hA5A5_0000, 5'd9, 1, 1, 2'd2, 0, 1, "stall");
            chk("stall.en", 64'(o_wb_en), 64'd0);
        end
        cycle(1, 0, 32'h0, 32'hA5A5_0000, 5'd9, 1, 1, 2'd2, 0, 0, "release");
        chk("release.en", 64'(o_wb_en), 64'd1);
        bubble("post_rel");
        chk("post_rel.en", 64'(o_wb_en), 64'd0);
        chk("post_rel.cnt", 64'(o_retired_cnt), 64'(cnt_snap + 1));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, 0, $urandom, $urandom,
                  5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                  "rand");
        end

        // Reset during DRAIN
        cycle(1, 1, 32'h0, 32'h0, 5'd3, 1, 1, 2'd2, 0, 0, "halt_a");
        chk("halt_a.nowrite", 64'(o_wb_en), 64'd0);
        bubble("drain_a");
        do_reset("mid_drain");
        cycle(1, 0, 32'h0, 32'h0000_0042, 5'd8, 1, 1, 2'd2, 0, 0, "after_rst");
        chk("after_rst.en", 64'(o_wb_en), 64'd1);
        chk("after_rst.cnt", 64'(o_retired_cnt), 64'd1);

        // Five instructions then HALT
        do_reset("pre_halt");
        for (int i = 1; i <= 5; i++)
            cycle(1, 0, 32'h0, 32'(i * 16), 5'(i), 1, 1, 2'd2, 0, 0, "five");
        cycle(1, 1, 32'h0, 32'h0, 5'd0, 1, 0, 2'd2, 0, 0, "halt_b");
        chk("halt_b.cnt", 64'(o_retired_cnt), 64'd6);
        chk("halt_b.halted0", 64'(o_halted), 64'd0);
        bubble("drain_b");
        chk("drain_b.halted", 64'(o_halted), 64'd0);
        cycle(1, 0, 32'h0, 32'h55, 5'd2, 1, 1, 2'd2, 0, 1, "drain_c");
        chk("drain_c.halted", 64'(o_halted), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 32'h0, 32'h77, 5'd3, 1, 1, 2'd2, 0, 0, "after_h");
            chk("after_h.en", 64'(o_wb_en), 64'd0);
            chk("after_h.cnt", 64'(o_retired_cnt), 64'd6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
